// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
//
// ID/EX pipeline register for a classic 5-stage MIPS-style pipeline, with
// load-use hazard detection and a saturating count of inserted bubbles.
//
// Each rising edge loads exactly one of three things into the EX stage,
// in priority order:
//   flush  : bubble (all control bits, ALUOp, valid and data fields = 0)
//   hazard : bubble, and bubble_cnt increments (saturating at all-ones)
//   normal : the ID instruction, with jump-related control sanitised
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                decoded ID-stage control, specifiers and data
//   id_is_*_type        decoded instruction class (hazard qualification)
//   flush               taken branch/jump in EX: kill the ID instruction
//   ex_*                registered copies of the id_* fields, plus ex_valid
//   pc_write            combinational PC enable (0 = hold)
//   ifid_write          combinational IF/ID enable (0 = hold)
//   bubble_cnt          number of load-use bubbles inserted so far
//
// Hold protocol: pc_write/ifid_write are enables for the upstream stages.
// When they are 0 during a cycle, the IF/ID register must present the same
// instruction again on the next cycle; the bubble inserted here on that edge
// clears ex_MemRead, so the hold lasts exactly one cycle per load.
// ---------------------------------------------------------------------------
module id_ex_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [2:0]        id_ALUOp,
  input  logic              id_RegDest,
  input  logic              id_RegWrite,
  input  logic              id_ALUSrc,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemToReg,
  input  logic              id_Branch,
  input  logic              id_invertzero,
  input  logic              id_Jump,

  input  logic              id_is_r_type,
  input  logic              id_is_i_type,
  input  logic              id_is_j_type,

  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [5:0]        id_funct,

  input  logic              flush,

  output logic [2:0]        ex_ALUOp,
  output logic              ex_RegDest,
  output logic              ex_RegWrite,
  output logic              ex_ALUSrc,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemToReg,
  output logic              ex_Branch,
  output logic              ex_invertzero,
  output logic              ex_Jump,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [5:0]        ex_funct,
  output logic              ex_valid,

  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Whole EX-stage payload as one register so bubble/reset are a single '0.
  typedef struct packed {
    logic [2:0]        alu_op;
    logic              reg_dest;
    logic              reg_write;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              invertzero;
    logic              jump;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [5:0]        funct;
    logic              valid;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             hz;

  // Instruction class is only needed by the decoder; i-type alone never
  // qualifies a hazard here.
  logic unused_is_i_type;
  assign unused_is_i_type = id_is_i_type;

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. rs is read by everything but jumps; rt is only a source for
  // R-type, branches and stores. $0 is never a real dependency.
  assign hz = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) &
              (((ex_q.rt == id_rs) & ~id_is_j_type) |
               ((ex_q.rt == id_rt) & (id_is_r_type | id_Branch | id_MemWrite)));

  // A flush discards the ID instruction anyway, so there is nothing to hold.
  assign pc_write   = flush | ~hz;
  assign ifid_write = flush | ~hz;

  always_comb begin
    ex_d         = '0;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hz) begin
      ex_d = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else begin
      // Jumps leave several decoder outputs as don't-cares; force the ones
      // that would trigger memory, branch or datapath muxing to 0.
      ex_d.alu_op     = id_Jump ? 3'd0 : id_ALUOp;
      ex_d.reg_dest   = id_RegDest  & ~id_Jump;
      ex_d.reg_write  = id_RegWrite;
      ex_d.alu_src    = id_ALUSrc   & ~id_Jump;
      ex_d.mem_read   = id_MemRead  & ~id_Jump;
      ex_d.mem_write  = id_MemWrite;
      ex_d.mem_to_reg = id_MemToReg & ~id_Jump;
      ex_d.branch     = id_Branch   & ~id_Jump;
      ex_d.invertzero = id_invertzero;
      ex_d.jump       = id_Jump;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
      ex_d.rdata1     = id_rdata1;
      ex_d.rdata2     = id_rdata2;
      ex_d.imm        = id_imm;
      ex_d.pc4        = id_pc4;
      ex_d.funct      = id_funct;
      ex_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_ALUOp      = ex_q.alu_op;
  assign ex_RegDest    = ex_q.reg_dest;
  assign ex_RegWrite   = ex_q.reg_write;
  assign ex_ALUSrc     = ex_q.alu_src;
  assign ex_MemRead    = ex_q.mem_read;
  assign ex_MemWrite   = ex_q.mem_write;
  assign ex_MemToReg   = ex_q.mem_to_reg;
  assign ex_Branch     = ex_q.branch;
  assign ex_invertzero = ex_q.invertzero;
  assign ex_Jump       = ex_q.jump;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_rdata1     = ex_q.rdata1;
  assign ex_rdata2     = ex_q.rdata2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc4        = ex_q.pc4;
  assign ex_funct      = ex_q.funct;
  assign ex_valid      = ex_q.valid;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the register-data, immediate and PC paths.
REQ-002 SHALL have parameter CNT_W, default 16: width of the saturating bubble counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_ALUOp in 3, id_RegDest, id_RegWrite, id_ALUSrc, id_MemRead, id_MemWrite, id_MemToReg, id_Branch, id_invertzero, id_Jump in 1 each  decoded ID-stage control bits.
REQ-006 id_is_r_type, id_is_i_type, id_is_j_type  in  1 each  decoded instruction class.
REQ-007 id_rs, id_rt, id_rd  in  5 each  register specifiers of the ID instruction.
REQ-008 id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-009 id_funct  in  6  function field.
REQ-010 flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
REQ-011 ex_* outputs  out  same widths as id_*  registered copies of REQ-005/007/008/009 signals, plus ex_valid out 1.
REQ-012 pc_write, ifid_write  out  1 each  combinational enables for PC and IF/ID register; 0 = hold.
REQ-013 bubble_cnt  out  CNT_W  count of inserted load-use bubbles.

Function
REQ-014 Load-use hazard (hz) SHALL be combinational: ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs & ~id_is_j_type) | (ex_rt == id_rt & (id_is_r_type | id_Branch | id_MemWrite))).
REQ-015 pc_write and ifid_write SHALL equal ~hz when flush = 0, and 1 when flush = 1.
REQ-016 Update priority per edge SHALL be: flush > hz > normal.
REQ-017 flush: all ex_ control bits, ex_ALUOp and ex_valid SHALL load 0; data/specifier fields don't-care (implementation loads 0).
REQ-018 hz (no flush): identical to flush load (bubble); bubble_cnt SHALL increment by 1, saturating at all-ones.
REQ-019 Normal: all ex_ fields SHALL load their id_ counterparts with 1-cycle latency; ex_valid SHALL load 1.
REQ-020 Sanitisation on normal load: ex_MemRead = id_MemRead & ~id_Jump; ex_Branch = id_Branch & ~id_Jump; ex_RegDest, ex_ALUSrc, ex_MemToReg, ex_ALUOp SHALL load 0 when id_Jump = 1; guarantees no X reaches EX from decoder don't-cares.
REQ-021 An all-zero instruction (all id_ control bits 0) SHALL be latched as a normal entry with ex_valid = 1 and no side effects.
REQ-022 Stall SHALL last exactly one cycle per load: after the bubble ex_MemRead = 0, so hz deasserts and the held instruction advances next edge.
REQ-023 flush and hz together: flush wins, no bubble counted, pc_write = ifid_write = 1.
REQ-024 Register $0 as load target SHALL never stall.

Reset
REQ-025 rst_n = 0 SHALL immediately (asynchronously) clear every ex_ output, ex_valid and bubble_cnt to 0, hence pc_write = ifid_write = 1.
REQ-026 Deassertion mid-stream SHALL resume with normal load on the first rising edge with rst_n = 1; no stall pending.

Verification
REQ-027 lw $8,0($9) then add $10,$8,$11 -> cycle after lw latched: hz = 1, pc_write = ifid_write = 0; next edge ex_valid = 0, ex_RegWrite = 0, bubble_cnt = 1; following edge add latched, ex_rs = 8.
REQ-028 lw $8 then addi $8,$12,5 (rt not a source) -> hz = 0 via rt; no stall, bubble_cnt stays 0; lw $0 then add using $0 -> no stall.
REQ-029 j with decoder driving MemRead/Branch = 1 -> ex_MemRead = 0, ex_Branch = 0, ex_Jump = 1, ex_ALUOp = 0.
REQ-030 flush = 1 coincident with hz = 1 -> ex_valid = 0, bubble_cnt unchanged, pc_write = 1.
REQ-031 CNT_W = 2, four consecutive load-use pairs -> bubble_cnt 1,2,3,3.
REQ-032 rst_n pulsed low between edges while ex_valid = 1 -> all outputs 0 before next edge; normal load resumes on first edge after release.
